inv_sweep_ctrl: RTL

//  Self-checking sequencer for the WIDTH-bit inverter datapath (invN).
//  On a start pulse it drives o_x through every code 0..2^WIDTH-1, waits

---
 rtl/inv_sweep_ctrl_pkg.sv | 4 +
 rtl/inv_sweep_ctrl_settle_timer.sv | 22 ++
 rtl/inv_sweep_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/inv_sweep_ctrl_pkg.sv
// inv_sweep_ctrl_pkg: state encoding shared by the sweep controller and its bench probes.
package inv_sweep_ctrl_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_t;
endpackage

// File: rtl/inv_sweep_ctrl_settle_timer.sv
// settle_timer: loadable down-counter that reloads to SETTLE-1 and flags zero.
module settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);
    localparam int CW = $clog2(SETTLE) + 1;
    logic [CW-1:0] r_cnt;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= CW'(SETTLE - 1);
        else if (i_dec && r_cnt != '0)
            r_cnt <= r_cnt - CW'(1);
    end
    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/inv_sweep_ctrl.sv
// inv_sweep_ctrl: sweeps o_x over every code, checks i_y == ~o_x after SETTLE cycles,
// counts mismatches (saturating) and keeps the first failing code.
module inv_sweep_ctrl
    import inv_sweep_ctrl_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1,
    parameter int ERR_W  = WIDTH + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic [WIDTH-1:0] o_x,
    input  logic [WIDTH-1:0] i_y,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic             o_fail,
    output logic [WIDTH-1:0] o_fail_x
);
    state_t r_state, w_next;
    logic [WIDTH-1:0] r_x, r_fail_x;
    logic [ERR_W-1:0] r_err_cnt;
    logic r_fail, r_done;
    logic w_zero, w_load, w_start, w_last, w_mis;
    assign w_start = (r_state == ST_IDLE || r_state == ST_DONE) && i_start;
    assign w_last  = &r_x;
    assign w_mis   = (i_y != ~r_x);
    settle_timer #(.SETTLE(SETTLE)) u_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_load),
        .i_dec  (r_state == ST_SETTLE),
        .o_zero (w_zero)
    );
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                w_next = w_start ? ST_SETTLE : r_state;
                w_load = w_start;
            end
            ST_SETTLE: w_next = w_zero ? ST_CHECK : ST_SETTLE;
            ST_CHECK: begin
                w_next = w_last ? ST_DONE : ST_SETTLE;
                w_load = !w_last;
            end
            default: w_next = ST_IDLE;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x       <= '0;
            r_err_cnt <= '0;
            r_fail    <= 1'b0;
            r_fail_x  <= '0;
            r_done    <= 1'b0;
        end else if (w_start) begin
            r_x       <= '0;
            r_err_cnt <= '0;
            r_fail    <= 1'b0;
            r_fail_x  <= '0;
            r_done    <= 1'b0;
        end else if (r_state == ST_CHECK) begin
            if (w_mis && r_err_cnt != '1)
                r_err_cnt <= r_err_cnt + ERR_W'(1);
            if (w_mis && !r_fail) begin
                r_fail   <= 1'b1;
                r_fail_x <= r_x;
            end
            if (w_last)
                r_done <= 1'b1;
            else
                r_x <= r_x + WIDTH'(1);
        end
    end
    assign o_x       = r_x;
    assign o_busy    = (r_state == ST_SETTLE) || (r_state == ST_CHECK);
    assign o_done    = r_done;
    assign o_pass    = r_done && (r_err_cnt == '0);
    assign o_err_cnt = r_err_cnt;
    assign o_fail    = r_fail;
    assign o_fail_x  = r_fail_x;
endmodule
